// File: rtl/aq_vfmau_pkg.sv
// Shared constants for the vector FMA multiplier scheduler: format bit
// positions, requester identities and a format-legality helper.
package aq_vfmau_pkg;

    // Bit positions inside the one-hot {bf16,f16,single,double} format field
    localparam int FMT_DOUBLE = 0;
    localparam int FMT_SINGLE = 1;
    localparam int FMT_F16    = 2;
    localparam int FMT_BF16   = 3;

    localparam logic SRC_MAIN    = 1'b0;
    localparam logic SRC_DIVSQRT = 1'b1;

    function automatic logic fmt_onehot(input logic [3:0] fmt);
        return (fmt != 4'd0) && ((fmt & (fmt - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/aq_vfmau_mult_arb.sv
// Two-way priority arbiter for the shared multiplier: the main FMA issue wins
// by default, and the div/sqrt requester is forced through after STARVE_MAX losses.
module aq_vfmau_mult_arb #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_vld,
    input  logic req1_vld,
    input  logic accept_en,
    output logic grant0,
    output logic grant1
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == STARVE_LIM);
    assign grant1  = req1_vld & (~req0_vld | starved);
    assign grant0  = req0_vld & ~grant1;

    // The count only moves in cycles where a grant can actually be taken, so
    // stalls, flushes and warm-up leave the fairness history untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (accept_en) begin
            if (grant0 & req1_vld) begin
                if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
            end else if (grant1 | ~req1_vld) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/aq_vfmau_mult_sched.sv
// Sequencer for the shared 53x53 fraction multiplier pipe (EX1 partial products,
// EX2 CSA/add): arbitration, EX1/EX2 valid tracking, pipe-down and flush.
module aq_vfmau_mult_sched
    import aq_vfmau_pkg::*;
#(
    parameter int TAG_W      = 2,
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             req0_vld,
    input  logic [3:0]       req0_fmt,
    input  logic [1:0]       req0_id_reg,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [3:0]       req1_fmt,
    input  logic [1:0]       req1_id_reg,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_rdy,
    input  logic             ctrl_flush,
    input  logic             ifu_vpu_warm_up,
    input  logic             ex2_rdy,
    output logic             ex1_double,
    output logic             ex1_single,
    output logic             ex1_f16,
    output logic             ex1_bf16,
    output logic [1:0]       ex1_id_reg,
    output logic             ex1_src_sel,
    output logic             ctrl_dp_ex1_inst_pipe_down,
    output logic             fmau_ex2_data_clk_en,
    output logic             ex2_vld,
    output logic             ex2_src,
    output logic [TAG_W-1:0] ex2_tag,
    output logic             fmt_err
);

    // Handshake: a requester's op is taken in any cycle where reqN_vld and
    // reqN_rdy are both high; ex2 result is consumed when ex2_vld and ex2_rdy.
    logic             ex1_vld;
    logic [TAG_W-1:0] ex1_tag;
    logic             grant0, grant1;
    logic             pipe_down, ex1_free, accept_en, accept;
    logic [3:0]       acc_fmt;
    logic             acc_legal;

    assign pipe_down = ex1_vld & (~ex2_vld | ex2_rdy) & ~ctrl_flush;
    assign ex1_free  = ~ex1_vld | pipe_down;
    assign accept_en = ex1_free & ~ctrl_flush & ~ifu_vpu_warm_up;

    aq_vfmau_mult_arb #(
        .STARVE_MAX(STARVE_MAX),
        .CNT_W     (CNT_W)
    ) u_arb (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .req0_vld (req0_vld),
        .req1_vld (req1_vld),
        .accept_en(accept_en),
        .grant0   (grant0),
        .grant1   (grant1)
    );

    assign req0_rdy  = grant0 & accept_en;
    assign req1_rdy  = grant1 & accept_en;
    assign accept    = req0_rdy | req1_rdy;
    assign acc_fmt   = grant1 ? req1_fmt : req0_fmt;
    assign acc_legal = fmt_onehot(acc_fmt);

    assign ctrl_dp_ex1_inst_pipe_down = pipe_down;
    // Warm-up keeps the EX2 registers toggling even with nothing in flight
    assign fmau_ex2_data_clk_en       = pipe_down | ifu_vpu_warm_up;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex1_vld     <= 1'b0;
            ex1_double  <= 1'b0;
            ex1_single  <= 1'b0;
            ex1_f16     <= 1'b0;
            ex1_bf16    <= 1'b0;
            ex1_id_reg  <= 2'b00;
            ex1_src_sel <= SRC_MAIN;
            ex1_tag     <= '0;
            fmt_err     <= 1'b0;
        end else begin
            if (ctrl_flush)     ex1_vld <= 1'b0;
            else if (accept)    ex1_vld <= 1'b1;
            else if (pipe_down) ex1_vld <= 1'b0;
            // Payload only loads on accept so it holds a stable value when empty
            if (accept) begin
                ex1_double  <= acc_legal & acc_fmt[FMT_DOUBLE];
                ex1_single  <= acc_legal & acc_fmt[FMT_SINGLE];
                ex1_f16     <= acc_legal & acc_fmt[FMT_F16];
                ex1_bf16    <= acc_legal & acc_fmt[FMT_BF16];
                ex1_id_reg  <= grant1 ? req1_id_reg : req0_id_reg;
                ex1_src_sel <= grant1 ? SRC_DIVSQRT : SRC_MAIN;
                ex1_tag     <= grant1 ? req1_tag : req0_tag;
                if (!acc_legal) fmt_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex2_vld <= 1'b0;
            ex2_src <= SRC_MAIN;
            ex2_tag <= '0;
        end else begin
            if (ctrl_flush)     ex2_vld <= 1'b0;
            else if (pipe_down) ex2_vld <= 1'b1;
            else if (ex2_rdy)   ex2_vld <= 1'b0;
            if (pipe_down) begin
                ex2_src <= ex1_src_sel;
                ex2_tag <= ex1_tag;
            end
        end
    end

endmodule
